// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// ----------------
// Sequences program-counter redirection and front-end squashing for the
// RV32IM pipeline. Takes the EX-stage branch decision and target, arbitrates
// a redirect against load-use stalls and instruction-memory back-pressure,
// and drives the PC mux / PC write enable and the IF/ID and ID/EX flush and
// stall controls.
//
// FSM:
//   IDLE   - normal fetch. A redirect event (EX_VALID & PC_SEL) is accepted
//            here only.
//   PEND   - redirect accepted but IMEM was busy; keep presenting the saved
//            target until the PC write actually happens.
//   SQUASH - PC has been redirected; wrong-path fetches still in flight
//            (FETCH_LAT of them) are flushed out of IF/ID.
//
// Parameters:
//   XLEN      address width
//   FETCH_LAT instruction-memory read latency (0..7) = squash cycles
//   CNT_W     width of the taken-redirect counter
//
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   PC_SEL, EX_VALID, TARGET  EX-stage branch/jump decision and target
//   IMEM_BUSY                 fetch cannot accept a new PC this cycle
//   HAZARD_STALL              load-use stall request
//   PC_WRITE, PC_MUX_SEL      PC register enable / mux select (1 = REDIRECT_PC)
//   REDIRECT_PC               redirect address
//   FLUSH_IFID, FLUSH_IDEX    bubble insertion into IF/ID, ID/EX
//   STALL_IFID                hold IF/ID
//   BUSY                      FSM not in IDLE
//   TAKEN_CNT                 saturating count of accepted redirects
//
// All outputs are combinational from state and inputs; no input reaches the
// state registers without passing through the clock edge.

module pc_redirect_ctrl #(
  parameter int XLEN      = 32,
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PC_SEL,
  input  logic             EX_VALID,
  input  logic [XLEN-1:0]  TARGET,
  input  logic             IMEM_BUSY,
  input  logic             HAZARD_STALL,
  output logic             PC_WRITE,
  output logic             PC_MUX_SEL,
  output logic [XLEN-1:0]  REDIRECT_PC,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             STALL_IFID,
  output logic             BUSY,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_SQUASH = 2'd2
  } state_t;

  localparam logic [2:0] LAT3    = FETCH_LAT[2:0];
  localparam bit         HAS_LAT = (FETCH_LAT > 0);

  state_t           r_state;
  logic [XLEN-1:0]  r_tgt_q;
  logic [2:0]       r_sq_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic w_redirect_ev;
  logic w_idle;

  assign w_idle        = (r_state == S_IDLE);
  // Redirects are only recognised in IDLE; during PEND/SQUASH EX carries
  // wrong-path or bubble instructions whose PC_SEL must not be honoured.
  assign w_redirect_ev = w_idle & EX_VALID & PC_SEL;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_tgt_q     <= '0;
      r_sq_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_redirect_ev) begin
            r_tgt_q <= TARGET;
            if (r_taken_cnt != {CNT_W{1'b1}}) begin
              r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (IMEM_BUSY) begin
              r_state <= S_PEND;
            end else if (HAS_LAT) begin
              r_state  <= S_SQUASH;
              r_sq_cnt <= LAT3;
            end
          end
        end

        S_PEND: begin
          if (!IMEM_BUSY) begin
            if (HAS_LAT) begin
              r_state  <= S_SQUASH;
              r_sq_cnt <= LAT3;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_SQUASH: begin
          r_sq_cnt <= r_sq_cnt - 3'd1;
          // A zero count can only appear through corruption; treat it as
          // the last squash cycle rather than wrapping to 7.
          if (r_sq_cnt <= 3'd1) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    PC_WRITE    = ~IMEM_BUSY;
    PC_MUX_SEL  = 1'b0;
    REDIRECT_PC = r_tgt_q;
    FLUSH_IFID  = 1'b0;
    FLUSH_IDEX  = 1'b0;
    STALL_IFID  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_redirect_ev) begin
          // Redirect beats a simultaneous load-use stall: the stalled
          // instruction is on the wrong path and gets flushed anyway.
          PC_MUX_SEL  = 1'b1;
          REDIRECT_PC = TARGET;
          FLUSH_IFID  = 1'b1;
          FLUSH_IDEX  = 1'b1;
        end else if (HAZARD_STALL) begin
          PC_WRITE   = 1'b0;
          STALL_IFID = 1'b1;
          FLUSH_IDEX = 1'b1;
        end
      end

      S_PEND: begin
        PC_MUX_SEL = 1'b1;
        FLUSH_IFID = 1'b1;
        FLUSH_IDEX = 1'b1;
      end

      S_SQUASH: begin
        FLUSH_IFID = 1'b1;
      end

      default: begin
      end
    endcase
  end

  assign BUSY      = ~w_idle;
  assign TAKEN_CNT = r_taken_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic clk;
  logic rst_n;

  // Main instance: FETCH_LAT=1, CNT_W=16
  logic        pc_sel, ex_valid, imem_busy, hazard;
  logic [31:0] target;
  logic        pc_write, pc_mux_sel, flush_ifid, flush_idex, stall_ifid, busy;
  logic [31:0] redirect_pc;
  logic [15:0] taken_cnt;

  // Saturation instance: FETCH_LAT=0, CNT_W=4
  logic        s_pc_sel, s_ex_valid, s_imem_busy, s_hazard;
  logic [31:0] s_target;
  logic        s_pc_write, s_pc_mux_sel, s_flush_ifid, s_flush_idex, s_stall_ifid, s_busy;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_redirect_ctrl #(.XLEN(32), .FETCH_LAT(1), .CNT_W(16)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .PC_SEL(pc_sel), .EX_VALID(ex_valid), .TARGET(target),
    .IMEM_BUSY(imem_busy), .HAZARD_STALL(hazard),
    .PC_WRITE(pc_write), .PC_MUX_SEL(pc_mux_sel), .REDIRECT_PC(redirect_pc),
    .FLUSH_IFID(flush_ifid), .FLUSH_IDEX(flush_idex), .STALL_IFID(stall_ifid),
    .BUSY(busy), .TAKEN_CNT(taken_cnt)
  );

  pc_redirect_ctrl #(.XLEN(32), .FETCH_LAT(0), .CNT_W(4)) dut_sat (
    .CLK(clk), .RESET_N(rst_n),
    .PC_SEL(s_pc_sel), .EX_VALID(s_ex_valid), .TARGET(s_target),
    .IMEM_BUSY(s_imem_busy), .HAZARD_STALL(s_hazard),
    .PC_WRITE(s_pc_write), .PC_MUX_SEL(s_pc_mux_sel), .REDIRECT_PC(s_redirect_pc),
    .FLUSH_IFID(s_flush_ifid), .FLUSH_IDEX(s_flush_idex), .STALL_IFID(s_stall_ifid),
    .BUSY(s_busy), .TAKEN_CNT(s_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_sel;
    logic        ex_valid;
    logic [31:0] target;
    logic        imem_busy;
    logic        hazard;
    logic        e_pw;
    logic        e_mux;
    logic [31:0] e_rpc;
    logic        e_fi;
    logic        e_fx;
    logic        e_st;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ps, input logic ev, input logic [31:0] tg,
                              input logic ib, input logic hz,
                              input logic pw, input logic mx, input logic [31:0] rp,
                              input logic fi, input logic fx, input logic st,
                              input logic bz, input logic [15:0] cn);
    vec_t v;
    v.pc_sel = ps; v.ex_valid = ev; v.target = tg; v.imem_busy = ib; v.hazard = hz;
    v.e_pw = pw; v.e_mux = mx; v.e_rpc = rp; v.e_fi = fi; v.e_fx = fx;
    v.e_st = st; v.e_busy = bz; v.e_cnt = cn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    pc_sel = 1'b0; ex_valid = 1'b0; target = 32'h0; imem_busy = 1'b0; hazard = 1'b0;
  endtask

  initial begin
    // Rows: inputs {pc_sel, ex_valid, target, imem_busy, hazard} then the
    // outputs expected in that same cycle {pc_write, mux, redirect_pc,
    // flush_ifid, flush_idex, stall_ifid, busy, taken_cnt}.
    // Free redirect to 0x100 (FETCH_LAT=1)
    vecs[0]  = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h000,1'b0,1'b0,1'b0,1'b0,16'd0);
    vecs[1]  = mk(1'b1,1'b1,32'h100,1'b0,1'b0, 1'b1,1'b1,32'h100,1'b1,1'b1,1'b0,1'b0,16'd0);
    vecs[2]  = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h100,1'b1,1'b0,1'b0,1'b1,16'd1);
    vecs[3]  = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h100,1'b0,1'b0,1'b0,1'b0,16'd1);
    // Invalid instruction: PC_SEL without EX_VALID
    vecs[4]  = mk(1'b1,1'b0,32'h500,1'b0,1'b0, 1'b1,1'b0,32'h100,1'b0,1'b0,1'b0,1'b0,16'd1);
    vecs[5]  = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h100,1'b0,1'b0,1'b0,1'b0,16'd1);
    // Hazard alone, then hazard together with redirect
    vecs[6]  = mk(1'b0,1'b0,32'h000,1'b0,1'b1, 1'b0,1'b0,32'h100,1'b0,1'b1,1'b1,1'b0,16'd1);
    vecs[7]  = mk(1'b1,1'b1,32'h180,1'b0,1'b1, 1'b1,1'b1,32'h180,1'b1,1'b1,1'b0,1'b0,16'd1);
    vecs[8]  = mk(1'b0,1'b0,32'h000,1'b0,1'b1, 1'b1,1'b0,32'h180,1'b1,1'b0,1'b0,1'b1,16'd2);
    vecs[9]  = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h180,1'b0,1'b0,1'b0,1'b0,16'd2);
    // Back-pressure: redirect to 0x200 with IMEM busy 3 cycles, 0x300 pulse in PEND
    vecs[10] = mk(1'b1,1'b1,32'h200,1'b1,1'b0, 1'b0,1'b1,32'h200,1'b1,1'b1,1'b0,1'b0,16'd2);
    vecs[11] = mk(1'b1,1'b1,32'h300,1'b1,1'b1, 1'b0,1'b1,32'h200,1'b1,1'b1,1'b0,1'b1,16'd3);
    vecs[12] = mk(1'b0,1'b0,32'h000,1'b1,1'b0, 1'b0,1'b1,32'h200,1'b1,1'b1,1'b0,1'b1,16'd3);
    vecs[13] = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b1,32'h200,1'b1,1'b1,1'b0,1'b1,16'd3);
    vecs[14] = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h200,1'b1,1'b0,1'b0,1'b1,16'd3);
    vecs[15] = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h200,1'b0,1'b0,1'b0,1'b0,16'd3);
    // Free redirect, then IMEM busy during SQUASH
    vecs[16] = mk(1'b1,1'b1,32'h040,1'b0,1'b0, 1'b1,1'b1,32'h040,1'b1,1'b1,1'b0,1'b0,16'd3);
    vecs[17] = mk(1'b0,1'b0,32'h000,1'b1,1'b0, 1'b0,1'b0,32'h040,1'b1,1'b0,1'b0,1'b1,16'd4);
    vecs[18] = mk(1'b0,1'b0,32'h000,1'b0,1'b0, 1'b1,1'b0,32'h040,1'b0,1'b0,1'b0,1'b0,16'd4);

    rst_n = 1'b0;
    drive_idle();
    s_pc_sel = 1'b0; s_ex_valid = 1'b0; s_target = 32'h0; s_imem_busy = 1'b0; s_hazard = 1'b0;

    // Reset state
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("reset_pc_write", {31'd0, pc_write}, 32'd1);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_flushes", {29'd0, flush_ifid, flush_idex, stall_ifid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      pc_sel = vecs[i].pc_sel; ex_valid = vecs[i].ex_valid; target = vecs[i].target;
      imem_busy = vecs[i].imem_busy; hazard = vecs[i].hazard;
      #1;
      $display("vec %0d: sel=%0b ev=%0b tgt=0x%0h ib=%0b hz=%0b -> pw=%0b mux=%0b rpc=0x%0h fi=%0b fx=%0b st=%0b busy=%0b cnt=%0d",
               i, pc_sel, ex_valid, target, imem_busy, hazard, pc_write, pc_mux_sel,
               redirect_pc, flush_ifid, flush_idex, stall_ifid, busy, taken_cnt);
      chk($sformatf("v%0d_pc_write", i),   {31'd0, pc_write},   {31'd0, vecs[i].e_pw});
      chk($sformatf("v%0d_pc_mux_sel", i), {31'd0, pc_mux_sel}, {31'd0, vecs[i].e_mux});
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc,        vecs[i].e_rpc);
      chk($sformatf("v%0d_flush_ifid", i), {31'd0, flush_ifid}, {31'd0, vecs[i].e_fi});
      chk($sformatf("v%0d_flush_idex", i), {31'd0, flush_idex}, {31'd0, vecs[i].e_fx});
      chk($sformatf("v%0d_stall_ifid", i), {31'd0, stall_ifid}, {31'd0, vecs[i].e_st});
      chk($sformatf("v%0d_busy", i),       {31'd0, busy},       {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_taken_cnt", i),  {16'd0, taken_cnt},  {16'd0, vecs[i].e_cnt});
    end

    // Async reset mid-SQUASH with TAKEN_CNT=5
    @(negedge clk);
    pc_sel = 1'b1; ex_valid = 1'b1; target = 32'h0000_0800;
    @(negedge clk);
    drive_idle();
    #1;
    $display("pre-reset: busy=%0b cnt=%0d fi=%0b", busy, taken_cnt, flush_ifid);
    chk("squash_busy", {31'd0, busy}, 32'd1);
    chk("squash_cnt", {16'd0, taken_cnt}, 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0b cnt=%0d pw=%0b fi=%0b fx=%0b", busy, taken_cnt, pc_write, flush_ifid, flush_idex);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("areset_pc_write", {31'd0, pc_write}, 32'd1);
    chk("areset_flushes", {29'd0, flush_ifid, flush_idex, stall_ifid}, 32'd0);
    chk("areset_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation: 17 back-to-back redirects, CNT_W=4, FETCH_LAT=0
    @(negedge clk);
    s_pc_sel = 1'b1; s_ex_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_target = 32'h1000 + 32'(i * 4);
      @(posedge clk);
      #1;
      $display("sat redirect %0d: cnt=%0d busy=%0b", i + 1, s_taken_cnt, s_busy);
      chk($sformatf("sat_cnt_%0d", i + 1), {28'd0, s_taken_cnt}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk($sformatf("sat_busy_%0d", i + 1), {31'd0, s_busy}, 32'd0);
    end
    @(negedge clk);
    s_pc_sel = 1'b0; s_ex_valid = 1'b0;
    #1;
    chk("sat_redirect_pc", s_redirect_pc, 32'h1040);
    chk("sat_final_cnt", {28'd0, s_taken_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
